// File: rtl/pingpong_ram_if.sv
// Ping-pong RAM controller bus: stream in, two-bank RAM port, stream out.
// master = controller side, slave = source/sink/RAM side.
interface pingpong_ram_if #(
  parameter int DATA_W = 10,
  parameter int AW     = 10
);
  logic [DATA_W-1:0] s_data;
  logic              s_tvalid;
  logic              s_tready;
  logic              ram0_we;
  logic              ram1_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [AW-1:0]     ram_raddr;
  logic [DATA_W-1:0] ram0_rdata;
  logic [DATA_W-1:0] ram1_rdata;
  logic [DATA_W-1:0] m_data;
  logic              m_tvalid;
  logic              m_tlast;
  logic              ovf;

  modport master (
    input  s_data,
    input  s_tvalid,
    output s_tready,
    output ram0_we,
    output ram1_we,
    output ram_waddr,
    output ram_wdata,
    output ram_raddr,
    input  ram0_rdata,
    input  ram1_rdata,
    output m_data,
    output m_tvalid,
    output m_tlast,
    output ovf
  );

  modport slave (
    output s_data,
    output s_tvalid,
    input  s_tready,
    input  ram0_we,
    input  ram1_we,
    input  ram_waddr,
    input  ram_wdata,
    input  ram_raddr,
    output ram0_rdata,
    output ram1_rdata,
    input  m_data,
    input  m_tvalid,
    input  m_tlast,
    input  ovf
  );
endinterface

// File: rtl/pingpong_ram_ctrl.sv
// Ping-pong buffer controller: fills one RAM bank from a stream while
// the other, already full bank is read out in order.
module pingpong_ram_ctrl #(
  parameter int DATA_W = 10,
  parameter int AW     = 10
) (
  input  logic          sclk,
  input  logic          rst_n,
  pingpong_ram_if.master bus
);

  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {
    IDLE,
    READ
  } rd_state_t;

  rd_state_t st_q, st_d;

  logic              wr_bank_q;
  logic [AW-1:0]     wr_cnt_q;
  logic              rd_bank_q, rd_bank_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [1:0]        full_q, full_d;

  logic              s_tready;
  logic              xfer;
  logic              wr_done;
  logic              rd_en;
  logic              rd_done;

  logic              we0_q, we1_q;
  logic [AW-1:0]     waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ovf_q;

  logic              rd_vld_q;
  logic              rd_sel_q;
  logic              rd_last_q;

  assign s_tready = !full_q[wr_bank_q];
  assign xfer     = bus.s_tvalid && s_tready;
  assign wr_done  = xfer && (wr_cnt_q == LAST);

  // Write side
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      we0_q     <= 1'b0;
      we1_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      we0_q <= xfer && !wr_bank_q;
      we1_q <= xfer && wr_bank_q;
      ovf_q <= bus.s_tvalid && !s_tready;
      if (xfer) begin
        waddr_q  <= wr_cnt_q;
        wdata_q  <= bus.s_data;
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (wr_done)
          wr_bank_q <= !wr_bank_q;
      end
    end
  end

  // Read FSM
  always_comb begin
    st_d      = st_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    rd_done   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          st_d     = READ;
          rd_cnt_d = '0;
        end
      end
      READ: begin
        rd_en    = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == LAST) begin
          rd_done   = 1'b1;
          rd_bank_d = !rd_bank_q;
          st_d      = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Fill and drain of different banks may land in the same cycle
  always_comb begin
    full_d = full_q;
    if (wr_done)
      full_d[wr_bank_q] = 1'b1;
    if (rd_done)
      full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= IDLE;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= '0;
      full_q    <= 2'b00;
      rd_vld_q  <= 1'b0;
      rd_sel_q  <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      rd_vld_q  <= rd_en;
      rd_sel_q  <= rd_bank_q;
      rd_last_q <= rd_en && (rd_cnt_q == LAST);
    end
  end

  assign bus.s_tready  = s_tready;
  assign bus.ram0_we   = we0_q;
  assign bus.ram1_we   = we1_q;
  assign bus.ram_waddr = waddr_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.ram_raddr = rd_cnt_q;
  assign bus.ovf       = ovf_q;
  assign bus.m_tvalid  = rd_vld_q;
  assign bus.m_tlast   = rd_last_q;
  assign bus.m_data    = !rd_vld_q ? '0
                       : rd_sel_q  ? bus.ram1_rdata
                       :             bus.ram0_rdata;

endmodule

// File: tb/tb_pingpong_ram_ctrl.sv
// Scoreboard bench for pingpong_ram_ctrl: random stream in, two behavioural
// RAM banks, every write and every output sample checked against queues.
module tb_pingpong_ram_ctrl;

  localparam int DW    = 10;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic sclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 sclk = ~sclk;

  pingpong_ram_if #(.DATA_W(DW), .AW(AW)) bus ();

  pingpong_ram_ctrl #(.DATA_W(DW), .AW(AW)) dut (
    .sclk  (sclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  always @(posedge sclk) begin
    if (bus.ram0_we) mem0[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram1_we) mem1[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram0_rdata <= mem0[bus.ram_raddr];
    bus.ram1_rdata <= mem1[bus.ram_raddr];
  end

  typedef struct {
    int bank;
    int addr;
    int data;
  } wr_t;

  typedef struct {
    int data;
    int last;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];

  int tests    = 0;
  int fails    = 0;
  int w_idx    = 0;
  int cyc      = 0;
  int t_last   = -100;
  int low_run  = 0;
  int ovf_seen = 0;
  bit seen_first = 0;
  bit prev_stall = 0;
  bit last_xfer  = 0;
  int seq = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    tests++;
    fails++;
    $display("FAIL %s", nm);
  endtask

  always @(posedge sclk) cyc++;

  // Monitor: compare what the last edge produced, then predict the next edge
  always @(negedge sclk) begin
    if (rst_n) begin
      wr_t w;
      rd_t r;
      check("ovf", 32'(bus.ovf), 32'(prev_stall));
      if (bus.ovf) ovf_seen++;
      if (bus.ram0_we && bus.ram1_we) flag("we_both");
      if (bus.ram0_we || bus.ram1_we) begin
        if (wq.size() == 0) begin
          flag("wr_unexpected");
        end else begin
          w = wq.pop_front();
          check("wr_bank", 32'(bus.ram1_we), 32'(w.bank));
          check("wr_addr", 32'(bus.ram_waddr), 32'(w.addr));
          check("wr_data", 32'(bus.ram_wdata), 32'(w.data));
        end
      end else if (wq.size() != 0) begin
        flag("wr_missing");
        void'(wq.pop_front());
      end
      if (bus.m_tvalid) begin
        if (!seen_first) begin
          seen_first = 1;
          check("first_rd_latency", 32'(cyc - t_last), 32'd2);
        end
        if (rq.size() == 0) begin
          flag("rd_unexpected");
        end else begin
          r = rq.pop_front();
          check("rd_data", 32'(bus.m_data), 32'(r.data));
          check("rd_last", 32'(bus.m_tlast), 32'(r.last));
        end
      end else if (bus.m_tlast) begin
        flag("tlast_without_valid");
      end
      if (!bus.s_tready) begin
        low_run++;
      end else if (low_run > 0) begin
        check("stall_len", 32'(low_run), 32'd1);
        low_run = 0;
      end
      prev_stall = bus.s_tvalid && !bus.s_tready;
      last_xfer  = bus.s_tvalid && bus.s_tready;
      if (last_xfer) begin
        wq.push_back('{bank: (w_idx / DEPTH) % 2, addr: w_idx % DEPTH,
                       data: int'(bus.s_data)});
        rq.push_back('{data: int'(bus.s_data),
                       last: int'((w_idx % DEPTH) == DEPTH - 1)});
        if (w_idx == DEPTH - 1) t_last = cyc + 1;
        w_idx++;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, 32'(bus.s_tready), 32'd1);
    check({tag, "_ram0_we"},  32'(bus.ram0_we),  32'd0);
    check({tag, "_ram1_we"},  32'(bus.ram1_we),  32'd0);
    check({tag, "_waddr"},    32'(bus.ram_waddr), 32'd0);
    check({tag, "_wdata"},    32'(bus.ram_wdata), 32'd0);
    check({tag, "_raddr"},    32'(bus.ram_raddr), 32'd0);
    check({tag, "_m_tvalid"}, 32'(bus.m_tvalid), 32'd0);
    check({tag, "_m_tlast"},  32'(bus.m_tlast),  32'd0);
    check({tag, "_m_data"},   32'(bus.m_data),   32'd0);
    check({tag, "_ovf"},      32'(bus.ovf),      32'd0);
  endtask

  task automatic flush_model();
    wq.delete();
    rq.delete();
    w_idx      = 0;
    t_last     = -100;
    seen_first = 0;
    prev_stall = 0;
    last_xfer  = 0;
    low_run    = 0;
  endtask

  // mode 0: continuous, 1: one cycle in three, 2: coin flip, 3: idle
  task automatic step(input int mode);
    bit v;
    @(posedge sclk);
    #1;
    if (bus.s_tvalid && !last_xfer) return;
    case (mode)
      0:       v = 1'b1;
      1:       v = ($urandom % 3) == 0;
      2:       v = $urandom % 2 == 1;
      default: v = 1'b0;
    endcase
    bus.s_tvalid = v;
    if (mode == 0) begin
      bus.s_data = DW'(seq);
      seq++;
    end else begin
      bus.s_data = DW'($urandom);
    end
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) step(mode);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.s_tvalid = 1'b0;
    bus.s_data   = '0;
    #3;
    check_reset_outputs("rst0");
    @(posedge sclk);
    #2 rst_n = 1'b1;

    run(4500, 0);
    run(5000, 1);
    run(3000, 2);

    begin
      int i = 0;
      while (i < 4000 && !(w_idx > DEPTH && (w_idx % DEPTH) == 500)) begin
        step(0);
        i++;
      end
      check("reach_mid_bank", 32'(w_idx % DEPTH), 32'd500);
    end

    @(posedge sclk);
    #2;
    rst_n        = 1'b0;
    bus.s_tvalid = 1'b0;
    flush_model();
    #1;
    check_reset_outputs("rst_mid");
    repeat (3) @(posedge sclk);
    #2 rst_n = 1'b1;

    run(2500, 0);
    run(2300, 3);

    check("ovf_seen", 32'(ovf_seen > 0), 32'd1);
    check("wq_empty", 32'(wq.size()), 32'd0);
    check("rq_partial", 32'(rq.size()), 32'(w_idx % DEPTH));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
